// File: rtl/bus_pkg.sv
// bus_pkg: shared widths and unpacker state encoding for the 24-bit bus stage
package bus_pkg;
    localparam int BUS_DATA_W     = 24;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 3;
    typedef enum logic [1:0] {EMPTY = 2'd0, HI = 2'd1, MID = 2'd2, LO = 2'd3} unpack_state_e;
endpackage

// File: rtl/bus_fifo.sv
// bus_fifo: synchronous circular-buffer FIFO with one-bit-wider pointers and a registered level
module bus_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             RSTn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = wr_ptr_q == rd_ptr_q;
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];
    assign level = level_q;
    // pointers wrap naturally modulo 2*DEPTH; level tracks push minus pop
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        level_d  = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
    // storage array needs no reset: contents are only read behind valid pointers
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
    // pointer and occupancy registers
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end
endmodule

// File: rtl/bus_unpack.sv
// bus_unpack: buffers 24-bit words and emits them MSB-first as 3 bytes; BUS_UNPACK_PARITY_EN adds per-byte even parity
module bus_unpack import bus_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    RSTn,
    input  logic                    in_valid,
    input  logic [BUS_DATA_W-1:0]   in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [BYTE_W-1:0]       out_data,
    output logic                    out_last,
    output logic                    out_parity,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  level
);
    logic                  full, empty, push, load, xfer;
    logic [BUS_DATA_W-1:0] fifo_rdata;
    unpack_state_e         state_q, state_d;
    logic [BUS_DATA_W-1:0] sreg_q, sreg_d;
    logic [BYTE_W-1:0]     out_data_q, out_data_d;
    logic                  out_last_q, out_last_d, out_valid_q, out_valid_d;
    assign in_ready  = !full;
    assign push      = in_valid && !full;
    assign xfer      = out_valid_q && out_ready;
    assign load      = !empty && (state_q == EMPTY || (state_q == LO && xfer));
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    bus_fifo #(.WIDTH(BUS_DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .RSTn  (RSTn),
        .push  (push),
        .pop   (load),
        .wdata (in_data),
        .rdata (fifo_rdata),
        .full  (full),
        .empty (empty),
        .level (level)
    );
    // next state: a load starts a fresh word at HI, a transfer rotates the next byte to the top
    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        out_last_d = out_last_q;
        if (load) begin
            state_d    = HI;
            sreg_d     = fifo_rdata;
            out_last_d = 1'b0;
        end else if (xfer) begin
            state_d    = state_q == HI ? MID : state_q == MID ? LO : EMPTY;
            sreg_d     = {sreg_q[BUS_DATA_W-BYTE_W-1:0], sreg_q[BUS_DATA_W-1 -: BYTE_W]};
            out_last_d = state_q == MID;
        end
        out_data_d  = (load || xfer) ? sreg_d[BUS_DATA_W-1 -: BYTE_W] : out_data_q;
        out_valid_d = state_d != EMPTY;
    end
    // FSM, shift register and registered byte outputs
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= EMPTY;
            sreg_q      <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end
`ifdef BUS_UNPACK_PARITY_EN
    logic out_parity_q, out_parity_d;
    assign out_parity = out_parity_q;
    // parity follows the byte register so it holds with it during a stall
    always_comb begin
        out_parity_d = (load || xfer) ? ^out_data_d : out_parity_q;
    end
    // parity register
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) out_parity_q <= 1'b0;
        else       out_parity_q <= out_parity_d;
    end
`else
    assign out_parity = 1'b0;
`endif
endmodule

// File: tb/tb_bus_unpack.sv
// tb_bus_unpack: directed and randomized checks of bus_unpack against a byte-queue reference model
module tb_bus_unpack;
    localparam int DEPTH = 4;
    logic        clk = 1'b0, RSTn = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [23:0] in_data = '0;
    logic        in_ready, out_valid, out_last, out_parity;
    logic [7:0]  out_data;
    logic [2:0]  level;
    int checks = 0, errors = 0;
    logic [9:0] exp_q[$], obs_q[$];

    bus_unpack #(.DEPTH(DEPTH)) dut (
        .clk(clk), .RSTn(RSTn), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_parity(out_parity),
        .out_ready(out_ready), .level(level)
    );

    always #5 clk = ~clk;

    function automatic logic par(input logic [7:0] b);
`ifdef BUS_UNPACK_PARITY_EN
        return ^b;
`else
        return 1'b0;
`endif
    endfunction

    // reference model: every accepted word expands into three bytes, MSB first, last flag on the third
    always @(negedge clk) if (RSTn) begin
        if (in_valid && in_ready)
            for (int i = 0; i < 3; i++)
                exp_q.push_back({i == 2, par(in_data[23-8*i -: 8]), in_data[23-8*i -: 8]});
        if (out_valid && out_ready) obs_q.push_back({out_last, out_parity, out_data});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        RSTn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick(); tick();
        RSTn = 1'b1;
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
        checks++; if ({out_data, out_last, out_parity} !== 10'd0) begin errors++; $display("FAIL reset_out_regs got %h/%b/%b want 0", out_data, out_last, out_parity); end
    endtask

    task automatic test_single();
        logic [23:0] w = 24'hA1B2C3;
        out_ready = 1'b1; in_data = w; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_latency got out_valid %b want 0", out_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== w[23-8*i -: 8] || out_last !== (i == 2)) begin
                errors++; $display("FAIL single_byte%0d got v%b %h l%b want v1 %h l%b", i, out_valid, out_data, out_last, w[23-8*i -: 8], i == 2);
            end
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_end got out_valid %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 24'h010203;
        tick();
        in_data = 24'h040506;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(i + 1) || out_last !== (i % 3 == 2)) begin
                errors++; $display("FAIL b2b_byte%0d got v%b %h l%b want v1 %h l%b", i, out_valid, out_data, out_last, 8'(i + 1), i % 3 == 2);
            end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got out_valid %b want 0", out_valid); end
    endtask

    task automatic test_parity();
        logic [23:0] w = 24'h078000;
        logic [2:0]  p = 3'b110;
        out_ready = 1'b1; in_data = w; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
`ifdef BUS_UNPACK_PARITY_EN
            checks++; if (out_parity !== p[2-i] || out_data !== w[23-8*i -: 8]) begin errors++; $display("FAIL parity_byte%0d got %h p%b want %h p%b", i, out_data, out_parity, w[23-8*i -: 8], p[2-i]); end
`else
            checks++; if (out_parity !== 1'b0 || out_data !== w[23-8*i -: 8]) begin errors++; $display("FAIL parity_byte%0d got %h p%b want %h p0", i, out_data, out_parity, w[23-8*i -: 8]); end
`endif
            tick();
        end
    endtask

    task automatic test_full_stall();
        logic [23:0] w[12];
        int k = 0;
        logic acc;
        exp_q.delete(); obs_q.delete();
        foreach (w[i]) w[i] = 24'($urandom);
        out_ready = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_data = w[k]; acc = in_ready;
            tick();
            if (acc) k++;
        end
        in_valid = 1'b0;
        checks++; if (k !== 5) begin errors++; $display("FAIL full_accepted got %0d want 5", k); end
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_level got %0d want 4", level); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b1 || out_data !== w[0][23:16]) begin errors++; $display("FAIL full_hold got v%b %h want v1 %h", out_valid, out_data, w[0][23:16]); end
        out_ready = 1'b1;
        repeat (20) tick();
        out_ready = 1'b0;
        checks++; if (obs_q.size() != 15 || exp_q.size() != 15) begin errors++; $display("FAIL full_drain_count got %0d want %0d (15)", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_drain_byte%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] w[3];
        foreach (w[i]) w[i] = 24'($urandom);
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = w[i];
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== w[0][15:8] || level !== 3'd2) begin errors++; $display("FAIL mid_setup got v%b %h lvl%0d want v1 %h lvl2", out_valid, out_data, level, w[0][15:8]); end
        #2 RSTn = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL mid_async_reset got v%b lvl%0d want v0 lvl0", out_valid, level); end
        tick();
        RSTn = 1'b1;
        exp_q.delete(); obs_q.delete();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 24'hFFEE00;
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hFF || out_last !== 1'b0) begin errors++; $display("FAIL mid_first_after_reset got v%b %h l%b want v1 ff l0", out_valid, out_data, out_last); end
        repeat (3) tick();
    endtask

    task automatic test_random();
        logic       stalled;
        logic [9:0] hd;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 24'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
            stalled   = out_valid && !out_ready;
            hd        = {out_last, out_parity, out_data};
            tick();
            if (stalled) begin
                checks++; if (out_valid !== 1'b1 || {out_last, out_parity, out_data} !== hd) begin errors++; $display("FAIL rand_hold cycle %0d got v%b %h want v1 %h", c, out_valid, {out_last, out_parity, out_data}, hd); end
            end
            checks++; if (level > DEPTH) begin errors++; $display("FAIL rand_level cycle %0d got %0d want <= %0d", c, level, DEPTH); end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (30) tick();
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_byte%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_full_stall();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
